ah_wrr_arbiter: RTL and testbench
=================================

Name: ah_wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter; next generation of the fixed 32-client round-robin arbiter in the AH arbitration library.
- Adds per-client credit weights, a beat-level accept handshake, multi-beat grant hold, optional packet lock, and client-withdrawal handling.
- Sits between N requesters and one shared resource (bus port, FIFO write side); the grant is registered.

Parameters:
- NUM_CLIENTS, 8, number of requesters (2..64).
- WEIGHT_W, 4, width of each per-client weight/credit field.
- LOCK_EN, 0, 1 = grant held until req_last beat regardless of credit.
- ID_W, $clog2(NUM_CLIENTS), width of gnt_id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_CLIENTS  per-client request, level.
- req_last  in  NUM_CLIENTS  per-client last-beat-of-packet flag, sampled on accepted beat.
- cfg_weight  in  NUM_CLIENTS*WEIGHT_W  flat weights, client i at [i*WEIGHT_W +: WEIGHT_W]; quasi-static.
- ack  in  1  resource accepts the current beat this cycle.
- gnt  out  NUM_CLIENTS  one-hot registered grant.
- gnt_id  out  ID_W  encoded index of the granted client; holds its last value when gnt==0.
- gnt_valid  out  1  |gnt.
- refill  out  1  one-cycle pulse when all credits are reloaded.

Behaviour:
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, refill=0, rotate pointer ptr=0, all credits=0, state IDLE.
- Reset is fully asynchronous. Reset mid-grant drops gnt immediately; the first post-reset request takes the refill path.
- Effective weight = cfg_weight[i], with 0 treated as 1.
- Eligible mask elig = req & (credit != 0).
- State IDLE (gnt==0):
  - If elig != 0: pick the first set bit of elig scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap). Next cycle gnt[c]=1, gnt_id=c, state GRANT.
  - Else if req != 0: load every credit from its effective weight, refill=1 for that cycle, stay IDLE. Arbitration happens the following cycle, so there is a one-cycle bubble.
  - Else: hold.
- State GRANT, client c. An accepted beat is gnt[c] & req[c] & ack.
  - Accepted beat: credit[c] decrements, saturating at 0.
  - Release when LOCK_EN=0: accepted beat and (req_last[c] or credit[c] reaches 0).
  - Release when LOCK_EN=1: accepted beat and req_last[c] only. Credit may sit at 0 while locked.
  - Withdrawal: req[c]==0 releases without decrementing. Withdrawal overrides lock.
  - On release: gnt=0 next cycle, ptr <= (c+1) mod NUM_CLIENTS, return to IDLE. There is always at least one idle cycle between grants; back-to-back grants to different clients are never produced.
  - ack without req[c] has no effect. ack low stalls: gnt and credit are unchanged.
- Latency: req rising in IDLE with credit available -> gnt 1 cycle later. With credits exhausted -> gnt 2 cycles later.
- Invariants:
  - gnt is at most one-hot.
  - gnt[i] implies req[i] was high in the granting cycle.
  - No client is starved: within NUM_CLIENTS grants plus one refill, every persistently requesting client is granted.
- cfg_weight changes take effect only at the next refill; current credits are never rewritten mid-round.

Test Plan:
- N=4, W=3, LOCK_EN=0, weights {3,1,2,1}, req=4'b1111, ack=1, req_last=0 -> refill pulse, then gnt_id sequence 0,0,0,idle,1,idle,2,2,idle,3,idle, refill, repeat.
- Same config, ack toggles 1/0 while client0 granted -> gnt held 5 cycles for 3 accepted beats; credit[0] decrements only on ack=1.
- req[2] dropped on its first granted cycle (credit 2) -> gnt=0 next cycle; ptr=3; credit[2] stays 2 and is used on the next visit without refill.
- Wrap: ptr=3, req=4'b1001, credits nonzero -> client 3 granted first, then client 0, then client 3 again.
- LOCK_EN=1, weight 1, client1 sends 4-beat packet with req_last on beat 4, req=4'b0011 -> gnt[1] held for all 4 accepted beats, then client0 granted.
- rst_n asserted while gnt=4'b0100 -> gnt=0 asynchronously; after release, req=4'b0100 -> refill pulse, then gnt=4'b0100 two cycles after the request is seen.

Source files
------------

// File: rtl/ah_wrr_arbiter.sv
// rtl/ah_wrr_arbiter.sv - weighted round-robin arbiter with credits, beat accept, grant hold and packet lock
module ah_wrr_arbiter #(
    parameter int NUM_CLIENTS = 8,
    parameter int WEIGHT_W    = 4,
    parameter int LOCK_EN     = 0,
    parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        req_last,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] cfg_weight,
    input  logic                          ack,
    output logic [NUM_CLIENTS-1:0]        gnt,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          gnt_valid,
    output logic                          refill
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]                state;
    logic [ID_W-1:0]           ptr;
    logic [WEIGHT_W-1:0]       credit     [NUM_CLIENTS];
    logic [WEIGHT_W-1:0]       eff_weight [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0]    elig;
    logic [2*NUM_CLIENTS-1:0]  elig_dbl;
    logic [NUM_CLIENTS-1:0]    elig_rot;
    logic                      pick_found;
    logic [ID_W-1:0]           pick_off;
    logic [ID_W:0]             pick_sum;
    logic [ID_W-1:0]           pick_id;
    logic                      cur_req;
    logic                      cur_last;
    logic [WEIGHT_W-1:0]       cur_credit;
    logic [WEIGHT_W-1:0]       cur_credit_dec;
    logic [ID_W-1:0]           ptr_next;

    // Eligibility and effective weights (a programmed weight of 0 still grants one beat).
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            elig[i] = req[i] & (credit[i] != '0);
            eff_weight[i] = (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                            WEIGHT_W'(1) : cfg_weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Rotate the eligible mask so bit 0 corresponds to ptr; the doubled copy handles the wrap.
    assign elig_dbl = {elig, elig} >> ptr;
    assign elig_rot = elig_dbl[NUM_CLIENTS-1:0];

    // Lowest set bit of the rotated mask is the offset of the winner from ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_off   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                pick_found = 1'b1;
                pick_off   = ID_W'(k);
            end
        end
    end

    assign pick_sum = {1'b0, ptr} + {1'b0, pick_off};
    assign pick_id  = (pick_sum >= (ID_W+1)'(NUM_CLIENTS)) ?
                      ID_W'(pick_sum - (ID_W+1)'(NUM_CLIENTS)) : pick_sum[ID_W-1:0];

    // Signals of the currently granted client; masked ORs avoid any out-of-range index.
    assign cur_req        = |(gnt & req);
    assign cur_last       = |(gnt & req_last);
    assign cur_credit     = credit[gnt_id];
    assign cur_credit_dec = (cur_credit == '0) ? '0 : cur_credit - 1'b1;
    assign ptr_next       = (gnt_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : gnt_id + 1'b1;
    assign gnt_valid      = |gnt;

    // Arbitration FSM: pick or refill while idle, hold and spend credit while granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            refill <= 1'b0;
            ptr    <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                credit[i] <= '0;
            end
        end else begin
            refill <= 1'b0;
            if (state == ST_IDLE) begin
                if (pick_found) begin
                    gnt    <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick_id;
                    gnt_id <= pick_id;
                    state  <= ST_GRANT;
                end else if (|req) begin
                    for (int i = 0; i < NUM_CLIENTS; i++) begin
                        credit[i] <= eff_weight[i];
                    end
                    refill <= 1'b1;
                end
            end else begin
                if (!cur_req) begin
                    // Withdrawal: release without spending credit, even inside a locked packet.
                    gnt   <= '0;
                    ptr   <= ptr_next;
                    state <= ST_IDLE;
                end else if (ack) begin
                    credit[gnt_id] <= cur_credit_dec;
                    if (cur_last || ((LOCK_EN == 0) && (cur_credit_dec == '0))) begin
                        gnt   <= '0;
                        ptr   <= ptr_next;
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ah_wrr_arbiter.sv
// tb/tb_ah_wrr_arbiter.sv - self-checking bench for ah_wrr_arbiter
module tb_ah_wrr_arbiter;

    localparam int N = 4;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_last = '0;
    logic           ack = 1'b0;
    logic [N*W-1:0] cfg_weight = '0;
    logic [N-1:0]   gnt0, gnt1;
    logic [1:0]     id0, id1;
    logic           gv0, gv1, rf0, rf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ah_wrr_arbiter #(.NUM_CLIENTS(N), .WEIGHT_W(W), .LOCK_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .cfg_weight(cfg_weight),
        .ack(ack), .gnt(gnt0), .gnt_id(id0), .gnt_valid(gv0), .refill(rf0)
    );

    ah_wrr_arbiter #(.NUM_CLIENTS(N), .WEIGHT_W(W), .LOCK_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .cfg_weight(cfg_weight),
        .ack(ack), .gnt(gnt1), .gnt_id(id1), .gnt_valid(gv1), .refill(rf1)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] last;
        logic [N-1:0] gnt;
        logic         refill;
    } vec_t;

    vec_t tbl [15];

    // Reference model state: index 0 models LOCK_EN=0, index 1 models LOCK_EN=1.
    int m_cred [2][N];
    int m_ptr  [2];
    int m_cur  [2];
    int m_id   [2];
    int m_rf   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic cyc(input int sel, input logic [N-1:0] r, input logic a, input logic [N-1:0] l,
                       input logic [N-1:0] eg, input logic erf, input string name);
        @(posedge clk);
        #1;
        req = r;
        ack = a;
        req_last = l;
        @(negedge clk);
        chk({name, " gnt"},    32'(sel != 0 ? gnt1 : gnt0), 32'(eg));
        chk({name, " refill"}, 32'(sel != 0 ? rf1 : rf0),   32'(erf));
        if (eg != '0) chk({name, " gnt_id"}, 32'(sel != 0 ? id1 : id0), 32'(onehot_idx(eg)));
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_ptr[s] = 0; m_cur[s] = -1; m_id[s] = 0; m_rf[s] = 0;
            for (int i = 0; i < N; i++) m_cred[s][i] = 0;
        end
    endfunction

    function automatic void model_step(input int s, input logic [N-1:0] r, input logic a,
                                       input logic [N-1:0] l, input logic [N*W-1:0] w);
        int c;
        int wv;
        int i;
        m_rf[s] = 0;
        if (m_cur[s] < 0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr[s] + k) % N;
                if (c < 0 && r[i] && m_cred[s][i] > 0) c = i;
            end
            if (c >= 0) begin
                m_cur[s] = c;
                m_id[s] = c;
            end else if (r != '0) begin
                for (int j = 0; j < N; j++) begin
                    wv = int'(w[j*W +: W]);
                    m_cred[s][j] = (wv == 0) ? 1 : wv;
                end
                m_rf[s] = 1;
            end
        end else begin
            c = m_cur[s];
            if (!r[c]) begin
                m_ptr[s] = (c + 1) % N;
                m_cur[s] = -1;
            end else if (a) begin
                if (m_cred[s][c] > 0) m_cred[s][c] = m_cred[s][c] - 1;
                if (l[c] || (s == 0 && m_cred[s][c] == 0)) begin
                    m_ptr[s] = (c + 1) % N;
                    m_cur[s] = -1;
                end
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        ack = 1'b0;
        req_last = '0;
        #1;
        chk("reset gnt",       32'(gnt0), 32'(0));
        chk("reset gnt_id",    32'(id0),  32'(0));
        chk("reset gnt_valid", 32'(gv0),  32'(0));
        chk("reset refill",    32'(rf0),  32'(0));
        chk("reset lock gnt",  32'(gnt1), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [7:0] act_v, exp_v;

    initial begin
        // Rotation through weights {3,1,2,1} with every client requesting and ack always high.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b0};
        tbl[12] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1};
        tbl[14] = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0};

        cfg_weight = {3'd1, 3'd2, 3'd1, 3'd3};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(0, tbl[i].req, tbl[i].ack, tbl[i].last, tbl[i].gnt, tbl[i].refill, $sformatf("rot%0d", i));
        end

        // Stall on client 0, then client 2 withdraws and keeps its credit for the next visit.
        do_reset();
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "st0");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, "st1");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, "st2");
        cyc(0, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, "st3");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, "st4");
        cyc(0, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0, "st5");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, "st6");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "st7");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, "st8");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "st9");
        cyc(0, 4'b1011, 1'b1, 4'b0000, 4'b0100, 1'b0, "wd10");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "wd11");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b0, "wd12");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "wd13");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, "wd14");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, "wd15");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "wd16");
        cyc(0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, "wd17");

        // Pointer wrap: ptr lands on 3 after client 2 withdraws; order 3, 0, 3.
        cfg_weight = {3'd2, 3'd2, 3'd1, 3'd1};
        do_reset();
        cyc(0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, "wr0");
        cyc(0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, "wr1");
        cyc(0, 4'b1001, 1'b1, 4'b0000, 4'b0100, 1'b0, "wr2");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b0, "wr3");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b1000, 1'b0, "wr4");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b0, "wr5");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0001, 1'b0, "wr6");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b0, "wr7");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b1000, 1'b0, "wr8");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b0, "wr9");
        cyc(0, 4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b1, "wr10");

        // Packet lock: client 1 (weight 1) keeps the grant for a 4-beat packet.
        cfg_weight = {3'd1, 3'd1, 3'd1, 3'd1};
        do_reset();
        cyc(1, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, "lk0");
        cyc(1, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1, "lk1");
        cyc(1, 4'b0011, 1'b1, 4'b0000, 4'b0010, 1'b0, "lk2");
        cyc(1, 4'b0011, 1'b1, 4'b0000, 4'b0010, 1'b0, "lk3");
        cyc(1, 4'b0011, 1'b1, 4'b0000, 4'b0010, 1'b0, "lk4");
        cyc(1, 4'b0011, 1'b1, 4'b0010, 4'b0010, 1'b0, "lk5");
        cyc(1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, "lk6");
        cyc(1, 4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b0, "lk7");
        cyc(1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, "lk8");

        // Asynchronous reset in the middle of a grant, then a fresh request takes the refill path.
        cfg_weight = {3'd1, 3'd2, 3'd1, 3'd3};
        do_reset();
        cyc(0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, "ar0");
        cyc(0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1, "ar1");
        cyc(0, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, "ar2");
        #1;
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("async reset gnt",       32'(gnt0), 32'(0));
        chk("async reset gnt_valid", 32'(gv0),  32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, "pr0");
        cyc(0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, "pr1");
        cyc(0, 4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, "pr2");

        // Randomized traffic on both lock settings against the reference model.
        cfg_weight = (N*W)'($urandom);
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) req[b] = ~req[b];
            ack = ($urandom_range(3) != 0);
            req_last = N'($urandom & $urandom);
            if ($urandom_range(199) == 0) cfg_weight = (N*W)'($urandom);
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                exp_v = {(m_cur[s] >= 0) ? (N'(1) << m_cur[s]) : N'(0), 2'(m_id[s]),
                         (m_cur[s] >= 0), (m_rf[s] != 0)};
                act_v = (s == 0) ? {gnt0, id0, gv0, rf0} : {gnt1, id1, gv1, rf1};
                chk($sformatf("rand lock%0d cycle %0d {gnt,id,valid,refill}", s, t),
                    32'(act_v), 32'(exp_v));
                model_step(s, req, ack, req_last, cfg_weight);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
